// File: rtl/reg_bank_decoded_pkg.sv
// Shared widths and the one-hot encoding helper for the decoded register bank.
// The default widths are used both by the bank and by its address decoder.
package reg_bank_decoded_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  // With en low the result is all zero; there is no fall-back to bit 0.
  function automatic logic [NUM_REGS-1:0] onehot_encode(
    input logic [REG_ADDR_W-1:0] addr,
    input logic                  en
  );
    logic [NUM_REGS-1:0] res;
    res = '0;
    if (en) res[addr] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/reg_bank_decoded_onehot_decoder.sv
// Purely combinational N-to-2^N one-hot decoder with an enable.
// At the package default width it reuses the shared encoding helper.
module onehot_decoder
  import reg_bank_decoded_pkg::*;
#(
  parameter int IN_W = REG_ADDR_W
) (
  input  logic              en,
  input  logic [IN_W-1:0]   sel,
  output logic [2**IN_W-1:0] out
);

  if (IN_W == REG_ADDR_W) begin : g_pkg
    assign out = onehot_encode(sel, en);
  end else begin : g_generic
    for (genvar i = 0; i < 2 ** IN_W; i++) begin : g_bit
      assign out[i] = en && (sel == IN_W'(i));
    end
  end

endmodule

// File: rtl/reg_bank_decoded.sv
// Register bank with decoded write enables, two combinational read ports,
// optional write-first bypass, optional hardwired-zero r0 and written-since-reset tracking.
module reg_bank_decoded
  import reg_bank_decoded_pkg::*;
#(
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [ADDR_W-1:0]   raddr_a,
  output logic [DATA_W-1:0]   rdata_a,
  output logic                rvalid_a,
  input  logic [ADDR_W-1:0]   raddr_b,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                rvalid_b,
  output logic [2**ADDR_W-1:0] wen_onehot,
  output logic [ADDR_W:0]     wr_count
);

  localparam int REG_COUNT = 2 ** ADDR_W;
  localparam int CNT_W     = ADDR_W + 1;

  localparam logic [REG_COUNT-1:0] VALID_RST = ZERO_R0 ? REG_COUNT'(1) : '0;
  localparam logic [REG_COUNT-1:0] WR_MASK   = ZERO_R0 ? ~REG_COUNT'(1) : '1;
  localparam logic [CNT_W-1:0]     CNT_RST   = ZERO_R0 ? CNT_W'(1) : '0;
  localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(REG_COUNT);

  logic [DATA_W-1:0]    regs [REG_COUNT];
  logic [REG_COUNT-1:0] valid;
  logic [REG_COUNT-1:0] onehot;
  logic [REG_COUNT-1:0] wr_en;
  logic                 first_write;

  onehot_decoder #(
    .IN_W (ADDR_W)
  ) u_decoder (
    .en  (we),
    .sel (waddr),
    .out (onehot)
  );

  // r0 is masked out of the storage enables but still shows up in wen_onehot.
  assign wr_en       = onehot & WR_MASK;
  assign first_write = |(wr_en & ~valid);

  // NOTE: the storage array is reset along with the control state because
  // every register must read 0 after reset; this rules out RAM-macro mapping.
  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers see pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      valid      <= VALID_RST;
      wen_onehot <= '0;
      wr_count   <= CNT_RST;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wr_en[i]) regs[i] <= wdata;
      end
      valid      <= valid | wr_en;
      wen_onehot <= onehot;
      if (first_write && (wr_count != CNT_MAX)) wr_count <= wr_count + CNT_W'(1);
    end
  end

  // Returns {valid, data} for one read address, applying bypass then the r0 override.
  function automatic logic [DATA_W:0] read_port(
    input logic [ADDR_W-1:0]    raddr,
    input logic [DATA_W-1:0]    stored,
    input logic                 stored_valid,
    input logic                 wr,
    input logic [ADDR_W-1:0]    wr_addr,
    input logic [DATA_W-1:0]    wr_data
  );
    logic [DATA_W:0] res;
    // NOTE: every path starts from a full default so the combinational
    // readout never holds a stale value (no latch).
    res = {stored_valid, stored};
    if (BYPASS && wr && (raddr == wr_addr) && !(ZERO_R0 && (wr_addr == '0)))
      res = {1'b1, wr_data};
    if (ZERO_R0 && (raddr == '0))
      res = {1'b1, {DATA_W{1'b0}}};
    return res;
  endfunction

  always_comb begin
    {rvalid_a, rdata_a} = read_port(raddr_a, regs[raddr_a], valid[raddr_a], we, waddr, wdata);
  end

  always_comb begin
    {rvalid_b, rdata_b} = read_port(raddr_b, regs[raddr_b], valid[raddr_b], we, waddr, wdata);
  end

endmodule

// File: doc/reg_bank_decoded.md
Name: reg_bank_decoded

Overview:
- Parametrised register bank, next generation of the processor's memory-stage write decoding.
- The write address passes through an internal N-to-2^N one-hot decoder to gate per-register write enables.
- Two asynchronous read ports, optional write-to-read bypass, optional hardwired-zero register 0, and a per-register written-since-reset valid bit.
- Sits between the ALU write-back path and the operand fetch of the datapath.

Parameters:
- ADDR_W, 3, address width; register count = 2**ADDR_W.
- DATA_W, 16, data width of each register.
- ZERO_R0, 1, 1 = register 0 reads as 0 and ignores writes; its valid bit stays 1.
- BYPASS, 1, 1 = a read of the address being written this cycle returns wdata (write-first); 0 = returns the old contents.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write request, sampled on clk rising edge.
- waddr  in  ADDR_W  write destination, decoded to a one-hot enable.
- wdata  in  DATA_W  write data.
- raddr_a  in  ADDR_W  read port A address.
- rdata_a  out  DATA_W  read port A data, combinational.
- rvalid_a  out  1  1 if register raddr_a has been written since reset.
- raddr_b  in  ADDR_W  read port B address.
- rdata_b  out  DATA_W  read port B data, combinational.
- rvalid_b  out  1  as rvalid_a, for port B.
- wen_onehot  out  2**ADDR_W  registered copy of last cycle's decoded write enable (debug/trace).
- wr_count  out  ADDR_W+1  number of distinct registers written since reset, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect without a clock edge):
  - all registers 0;
  - valid bits 0, except bit 0 = 1 when ZERO_R0=1;
  - wen_onehot 0;
  - wr_count 0, or 1 when ZERO_R0=1.
  - Reset asserted mid-write aborts the write; no partial update.
- Decoder:
  - onehot = we ? (1 << waddr) : 0.
  - Exactly one bit is set when we=1; all zero when we=0. No default-to-bit-0 case.
- Write:
  - On a clk rising edge with we=1 and onehot[i]=1: reg[i] <= wdata and valid[i] <= 1.
  - Latency 1 cycle; a non-bypassed read sees the new value the cycle after.
  - If ZERO_R0=1 and waddr=0: reg[0] is not updated and wr_count is unchanged. wen_onehot still records bit 0.
- wen_onehot <= onehot on every edge; it returns to 0 the cycle after we falls.
- wr_count:
  - Increments by 1 on a write to a register whose valid bit was 0.
  - Saturates at 2**ADDR_W.
  - Rewriting an already-valid register does not increment it.
- Reads:
  - rdata_x = reg[raddr_x]; rvalid_x = valid[raddr_x].
  - ZERO_R0=1 and raddr_x=0: rdata_x=0, rvalid_x=1 regardless of writes.
- Bypass:
  - BYPASS=1, we=1, raddr_x==waddr, and not (ZERO_R0 and waddr==0): rdata_x=wdata and rvalid_x=1 in the same cycle.
  - Both ports may bypass the same write simultaneously.
- Ports A and B are fully independent; reading the same address on both ports returns identical data.
- No stall or back-pressure; a write is accepted every cycle.

Decomposition:
- Shared package holds:
  - default widths (REG_ADDR_W=3, REG_DATA_W=16);
  - localparam NUM_REGS = 2**ADDR_W;
  - function onehot_encode(addr, en).
- One sub-module, onehot_decoder:
  - parameters IN_W;
  - inputs en, sel[IN_W-1:0]; output out[2**IN_W-1:0];
  - purely combinational.
- Storage, valid bits, counter and bypass muxing live in reg_bank_decoded.

Test Plan (ADDR_W=3, DATA_W=16 throughout):
1. Reset: rst_n low mid-cycle, no clock -> all rdata=0; rvalid=0 except address 0; wr_count=1; wen_onehot=0 immediately.
2. Write sweep: we=1, waddr=1..7, wdata=16'h1111*addr, one write per cycle -> next-cycle reads return those values; wen_onehot walks 8'h02..8'h80; wr_count ends at 8.
3. Bypass: BYPASS=1, we=1, waddr=5, wdata=16'hBEEF, raddr_a=raddr_b=5 -> both rdata=16'hBEEF in the same cycle. Repeat with BYPASS=0 -> both ports return the old value, then 16'hBEEF next cycle.
4. Zero register: we=1, waddr=0, wdata=16'hFFFF -> rdata for address 0 stays 0; wen_onehot=8'h01 next cycle; wr_count unchanged.
5. Rewrite and idle: write addr 3 twice with 16'h0A0A then 16'h0B0B -> wr_count increments once; read returns 16'h0B0B. Then we=0 with waddr toggling -> no register changes; wen_onehot=0.
6. Reset mid-operation: rst_n pulsed low between two writes to addr 2 -> addr 2 reads 0 with rvalid=0; the next write sets rvalid=1; wr_count=2.
